// File: rtl/wam_hit_pkg.sv
// wam_hit_pkg: shared constants and helpers for the whac-a-mole hit stage.
// Contents: hole count, BCD saturation limit, popcount8, bcd2_add_sat.
// Both helpers are pure combinational functions.
package wam_hit_pkg;

  localparam int         WAM_N_HOLES = 8;
  localparam logic [7:0] WAM_BCD_MAX = 8'h99;

  // Number of set bits in an 8-bit vector (0..8).
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

  // Add a small increment (0..8) to a 2-digit BCD value in one step.
  // The units digit can reach at most 9+8=17, so a single decimal
  // correction is enough. A tens overflow clamps the result to 99.
  function automatic logic [7:0] bcd2_add_sat(input logic [7:0] bcd8,
                                              input logic [3:0] inc4);
    logic [4:0] units;
    logic [4:0] tens;
    units = {1'b0, bcd8[3:0]} + {1'b0, inc4};
    tens  = {1'b0, bcd8[7:4]};
    if (units > 5'd9) begin
      units = units - 5'd10;
      tens  = tens + 5'd1;
    end
    if (tens > 5'd9) begin
      return WAM_BCD_MAX;
    end
    return {tens[3:0], units[3:0]};
  endfunction

endpackage

// File: rtl/wam_db.sv
// wam_db: one button channel - 2-flop synchroniser, DB_LEN-sample
// debouncer and rising-edge detect.
// Ports: clk, clr (async, active-high), raw (async button level),
//        level (debounced level), rise (high in the cycle level is about
//        to go 0->1, i.e. combinational; the consumer registers it).
module wam_db #(
  parameter int DB_LEN = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic              s1;
  logic              s2;
  logic [DB_LEN-1:0] sh;
  logic              db;
  logic              db_next;

  // The debounced level only moves once the whole history window agrees
  // with the synchronised input and disagrees with the current level.
  always_comb begin
    db_next = db;
    if ((sh == {DB_LEN{s2}}) && (s2 != db)) begin
      db_next = s2;
    end
  end

  // Rise is taken from the next-state value so the consumer can register
  // the press on the same edge that sets db.
  assign rise  = db_next & ~db;
  assign level = db;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      sh <= '0;
      db <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      sh <= {sh[DB_LEN-2:0], s2};
      db <= db_next;
    end
  end

endmodule

// File: rtl/wam_hit.sv
// wam_hit: conditions the hole buttons and qualifies each press against
// the mole mask, producing one-cycle hit/miss pulses and BCD tallies.
// Ports: clk, clr (async, active-high), btn, run, holes in;
//        hit, miss (registered pulses), hit_bcd, miss_bcd (0..99) out.
module wam_hit
  import wam_hit_pkg::*;
#(
  parameter int N_HOLES = WAM_N_HOLES,
  parameter int DB_LEN  = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [N_HOLES-1:0] btn,
  input  logic               run,
  input  logic [N_HOLES-1:0] holes,
  output logic [N_HOLES-1:0] hit,
  output logic [N_HOLES-1:0] miss,
  output logic [7:0]         hit_bcd,
  output logic [7:0]         miss_bcd
);

  logic [N_HOLES-1:0] levels;
  logic [N_HOLES-1:0] rises;
  logic [N_HOLES-1:0] hit_next;
  logic [N_HOLES-1:0] miss_next;

  for (genvar i = 0; i < N_HOLES; i++) begin : g_btn
    wam_db #(
      .DB_LEN(DB_LEN)
    ) u_db (
      .clk  (clk),
      .clr  (clr),
      .raw  (btn[i]),
      .level(levels[i]),
      .rise (rises[i])
    );
  end

  // A press while the game is idle is swallowed; because db keeps
  // tracking the button, a held button cannot fire later when run rises.
  always_comb begin
    hit_next  = '0;
    miss_next = '0;
    if (run) begin
      hit_next  = rises & holes;
      miss_next = rises & ~holes;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hit      <= '0;
      miss     <= '0;
      hit_bcd  <= 8'h00;
      miss_bcd <= 8'h00;
    end else begin
      hit      <= hit_next;
      miss     <= miss_next;
      hit_bcd  <= bcd2_add_sat(hit_bcd, popcount8(hit_next));
      miss_bcd <= bcd2_add_sat(miss_bcd, popcount8(miss_next));
    end
  end

  // A pulse is registered on the same edge the debounced level rises, so
  // every pulsing bit must have its debounced level high.
  a_pulse_has_level : assert property (@(posedge clk) disable iff (clr)
    ((hit | miss) & ~levels) == '0);
  a_hit_miss_excl : assert property (@(posedge clk) disable iff (clr)
    (hit & miss) == '0);

endmodule
